// File: rtl/mod_counter.sv
// mod_counter -- modulo up/down counter with prescaler, wrap/saturate modes,
// synchronous load and overflow flags.
//
// Parameters
//   WIDTH     bit width of count and load_val
//   MODULUS   count range is 0..MODULUS-1 (2..2^WIDTH)
//   PRESCALE  enabled cycles per count step (1..65536)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   en          count enable, gates the prescaler
//   dir         0 = count up, 1 = count down
//   sat         0 = wrap at the range boundary, 1 = saturate
//   load        synchronous load strobe (wins over a step)
//   load_val    value to load, clamped to MODULUS-1
//   clr_ovf     clears ovf_sticky on the next edge
//   count       registered count value
//   tc          combinational terminal-count flag
//   wrap        registered one-cycle pulse after a wrapping step
//   ovf_sticky  sticky flag for any boundary step (wrap or saturation)
//
// There is no handshake on this block: every output is valid every cycle.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam int              PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
  // Range constants are WIDTH+1 bits so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0]  MOD_W   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]  CNT_MAX = (WIDTH + 1)'(MODULUS - 1);

  logic [PW-1:0]    psc;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   load_x;
  logic             step;
  logic             at_top;
  logic             at_bottom;
  logic             at_bound;
  logic [WIDTH-1:0] cnt_stepped;
  logic [WIDTH-1:0] cnt_loaded;

  always_comb begin
    cnt_x     = {1'b0, count};
    cnt_inc   = cnt_x + 1'b1;
    // The top of the range is detected as count+1 == MODULUS in the wide
    // domain, which is exact even when MODULUS fills the whole WIDTH range.
    at_top    = (cnt_inc == MOD_W);
    at_bottom = (cnt_x == '0);
    at_bound  = dir ? at_bottom : at_top;
    step      = en && (psc == PS_LAST);

    cnt_stepped = count;
    if (at_bound) begin
      if (!sat) cnt_stepped = dir ? CNT_MAX[WIDTH-1:0] : '0;
    end else begin
      cnt_stepped = dir ? (count - 1'b1) : cnt_inc[WIDTH-1:0];
    end

    load_x     = {1'b0, load_val};
    cnt_loaded = (load_x > CNT_MAX) ? CNT_MAX[WIDTH-1:0] : load_val;

    // During reset the count is treated as 0 regardless of the register, so
    // only a down-counting enabled counter reports terminal count.
    tc = en && (rst ? dir : at_bound);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      psc        <= '0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= cnt_loaded;
        psc   <= '0;
      end else if (en) begin
        if (step) begin
          psc   <= '0;
          count <= cnt_stepped;
          wrap  <= at_bound && !sat;
        end else begin
          psc <= psc + 1'b1;
        end
      end

      // A boundary step sets the flag and beats a simultaneous clear.
      if (!load && step && at_bound) begin
        ovf_sticky <= 1'b1;
      end else if (clr_ovf) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter -- bench for mod_counter.
// Two instances share one stimulus stream:
//   dut0: WIDTH=4, MODULUS=10, PRESCALE=3 (clamped loads, prescaled steps)
//   dut1: WIDTH=4, MODULUS=16, PRESCALE=1 (range fills the full WIDTH)
// The driver applies inputs on the falling edge and pushes a snapshot of the
// outputs expected during that cycle; the monitor pops and compares shortly
// after, while the same inputs are still applied.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, sat, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] count0, count1;
  logic       tc0, tc1, wrap0, wrap1, ovf0, ovf1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit done        = 1'b0;

  // snapshot layout: {count[3:0], tc, wrap, ovf_sticky}
  logic [6:0] exp_q0[$];
  logic [6:0] exp_q1[$];

  // reference model state, one slot per instance
  int mods[2] = '{10, 16};
  int pres[2] = '{3, 1};
  int m_cnt[2];
  int m_psc[2];
  bit m_wrap[2];
  bit m_ovf[2];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count0), .tc(tc0),
    .wrap(wrap0), .ovf_sticky(ovf0)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count1), .tc(tc1),
    .wrap(wrap1), .ovf_sticky(ovf1)
  );

  // ---------------- reference model ----------------
  // Snapshot what instance k shows this cycle, then advance it by one edge.
  task automatic model_cycle(input int k, input bit r, input bit e, input bit d,
                             input bit s, input bit ld, input int lv,
                             input bit co, output logic [6:0] snap);
    int m = mods[k];
    int p = pres[k];
    int c = m_cnt[k];
    int ps = m_psc[k];
    bit ov = m_ovf[k];
    bit nw = 1'b0;
    bit bstep = 1'b0;
    bit t;
    if (r) t = e && d;
    else   t = e && (d ? (c == 0) : (c == m - 1));
    snap = {4'(c), t, m_wrap[k], ov};

    if (r) begin
      c = 0; ps = 0; ov = 1'b0;
    end else begin
      if (ld) begin
        c  = (lv >= m) ? m - 1 : lv;
        ps = 0;
      end else if (e) begin
        if (ps == p - 1) begin
          ps = 0;
          if (!d) begin
            if (c == m - 1) begin
              bstep = 1'b1;
              if (!s) begin c = 0; nw = 1'b1; end
            end else c = c + 1;
          end else begin
            if (c == 0) begin
              bstep = 1'b1;
              if (!s) begin c = m - 1; nw = 1'b1; end
            end else c = c - 1;
          end
        end else begin
          ps = ps + 1;
        end
      end
      if (bstep) ov = 1'b1;
      else if (co) ov = 1'b0;
    end
    m_cnt[k]  = c;
    m_psc[k]  = ps;
    m_wrap[k] = nw;
    m_ovf[k]  = ov;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e, input bit d, input bit s,
                       input bit ld, input int lv, input bit co);
    logic [6:0] snap;
    @(negedge clk);
    rst = r; en = e; dir = d; sat = s; load = ld;
    load_val = 4'(lv); clr_ovf = co;
    model_cycle(0, r, e, d, s, ld, lv, co, snap);
    exp_q0.push_back(snap);
    model_cycle(1, r, e, d, s, ld, lv, co, snap);
    exp_q1.push_back(snap);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input int k, input logic [6:0] got);
    logic [6:0] e;
    vectors++;
    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      miscompares++;
      $display("FAIL dut%0d cycle %0d: output present but no expected entry", k, cyc);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (got !== e) begin
        miscompares++;
        $display("FAIL dut%0d cycle %0d: got count=%0d tc=%b wrap=%b ovf=%b, exp count=%0d tc=%b wrap=%b ovf=%b",
                 k, cyc, got[6:3], got[2], got[1], got[0], e[6:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      if (done) break;
      check(0, {count0, tc0, wrap0, ovf0});
      check(1, {count1, tc1, wrap1, ovf1});
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit d_s, s_s;
    rst = 1'b1; en = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0;
    load_val = '0; clr_ovf = 1'b0;
    // Registers are unknown before the first edge; bring the DUTs into reset
    // without checking, then start the model from the reset state.
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_psc[k] = 0; m_wrap[k] = 1'b0; m_ovf[k] = 1'b0;
    end

    // directed: reset with enable high, then count up through a wrap
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 34; i++) drive(0, 1, 0, 0, 0, 0, 0);
    // pause mid-phase, then resume
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0);
    // down with saturation from reset (tc during reset with dir=1)
    drive(1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 1, 0, 0, 0);
    // clear the sticky flag alone
    drive(0, 0, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 0);
    // clamped load, then in-range load with enable high, then reset mid-load
    drive(0, 1, 0, 0, 1, 15, 0);
    drive(0, 1, 0, 0, 1, 5, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0, (i % 3) == 0);
    drive(1, 1, 0, 0, 1, 7, 1);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 1, 0, 0, 0);

    // randomized
    d_s = 1'b0;
    s_s = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) d_s = ~d_s;
      if ($urandom_range(0, 29) == 0) s_s = ~s_s;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8, d_s, s_s,
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    done = 1'b1;
    #5;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d/%0d expected entries never compared, required 0",
               exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: run did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of count and load_val.
REQ-002 Parameter MODULUS, default 256: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter PRESCALE, default 1: number of enabled cycles per count step; legal range 1..65536.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  count enable; gates the prescaler.
REQ-007 dir  input  1  0 = count up, 1 = count down.
REQ-008 sat  input  1  0 = wrap at the range boundary, 1 = saturate at the range boundary.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 clr_ovf  input  1  clears ovf_sticky.
REQ-012 count  output  WIDTH  registered count value.
REQ-013 tc  output  1  combinational terminal-count flag.
REQ-014 wrap  output  1  registered one-cycle pulse marking a wrap.
REQ-015 ovf_sticky  output  1  registered sticky flag for a boundary crossing or saturation attempt.

Function
REQ-016 Input priority each edge SHALL be rst > load > step; clr_ovf is evaluated independently.
REQ-017 Prescaler: an internal counter of width clog2(PRESCALE)+1 SHALL increment on each en=1 cycle.
- When it equals PRESCALE-1 and en=1, a step occurs and the prescaler returns to 0.
- With PRESCALE=1, every en=1 cycle is a step.
REQ-018 en=0 SHALL freeze count, the prescaler and all flags except clr_ovf handling.
REQ-019 Up step: count SHALL go to count+1, or on reaching MODULUS-1:
- sat=0: next value is 0.
- sat=1: count holds at MODULUS-1.
REQ-020 Down step: count SHALL go to count-1, or on reaching 0:
- sat=0: next value is MODULUS-1.
- sat=1: count holds at 0.
REQ-021 Arithmetic SHALL use WIDTH+1 bits internally so that MODULUS=2^WIDTH wraps without truncation error.
REQ-022 Load: count SHALL take load_val the next edge, clamped to MODULUS-1 when load_val >= MODULUS.
- The prescaler clears to 0.
- No step occurs that cycle, regardless of en.
REQ-023 Terminal value: tc SHALL be 1 when the terminal value is reached, else 0.
- Up: en=1 and count=MODULUS-1.
- Down: en=1 and count=0.
- tc does not depend on the prescaler phase.
REQ-024 wrap SHALL be 1 for exactly the cycle after a step that crossed the boundary with sat=0, else 0.
REQ-025 ovf_sticky SHALL set on the edge of any boundary step, for both wraps (sat=0) and saturation attempts (sat=1).
- It remains set until cleared.
- clr_ovf=1 clears it on the next edge.
- A simultaneous set and clr_ovf leaves it set.
REQ-026 Changing dir or sat between steps SHALL take effect at the next step and SHALL NOT reset the prescaler.
REQ-027 Simultaneous load and boundary condition: load wins; wrap stays 0 and ovf_sticky is unchanged, except for clr_ovf.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL clear to 0: count, the prescaler, wrap and ovf_sticky.
REQ-029 Reset SHALL dominate load, en and clr_ovf.
REQ-030 Reset asserted mid-prescale or mid-count SHALL discard the partial prescale phase.
REQ-031 While rst=1, tc SHALL follow REQ-023 with count=0; it is 1 only if en=1 and dir=1.

Verification
REQ-032 WIDTH=8, MODULUS=10, PRESCALE=1, en=1, dir=0, sat=0 from reset, 12 cycles -> count is 0..9,0,1; tc=1 at count 9; wrap=1 the cycle count=0 appears; ovf_sticky=1 from then on.
REQ-033 Same configuration with dir=1, sat=1 from reset, 3 cycles -> count stays 0, tc=1, wrap=0, ovf_sticky=1 after the first edge.
REQ-034 PRESCALE=3, MODULUS=256, en=1, dir=0 -> count increments once every 3 cycles: 0,0,0,1,1,1,2.
- Deasserting en for 2 cycles mid-phase delays the next step by exactly 2 cycles.
REQ-035 MODULUS=10, load=1 with load_val=200 -> count=9 next cycle; load_val=5 with en=1 -> count=5, no step that cycle, prescaler cleared.
REQ-036 ovf_sticky=1, then clr_ovf=1 on the same edge as a wrap -> ovf_sticky stays 1; clr_ovf=1 alone next cycle -> 0.
REQ-037 WIDTH=4, MODULUS=16, count=15, up step with sat=0 -> count=0, wrap=1; rst=1 during PRESCALE=4 phase 2 -> next count step occurs 4 enabled cycles after rst releases.
